// File: rtl/pattern_seq_detector.sv
// Serial pattern detector: compares the last PAT_W valid bits against a
// runtime pattern, with overlapping/non-overlapping modes and a saturating match counter.
module pattern_seq_detector #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clear,
    output logic             seq_detected,
    output logic             detected_sticky,
    output logic [CNT_W-1:0] match_count
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              det_q, det_d;
    logic              sticky_q, sticky_d;

    logic [PAT_W-1:0]  window;
    logic              fill_ok;
    logic              match;

    // The window is the history as it will look once bit_in is shifted in;
    // the oldest history bit falls off the top.
    assign window  = PAT_W'({hist_q, bit_in});
    assign fill_ok = (int'(fill_q) + 1) >= PAT_W;
    assign match   = bit_valid && fill_ok && (window == pattern);

    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        count_d  = count_q;
        sticky_d = sticky_q;
        det_d    = 1'b0;

        if (clear) begin
            // Clear wins over a coincident match and drops the partial history.
            hist_d   = '0;
            fill_d   = '0;
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (bit_valid) begin
            hist_d = window;
            if (match) begin
                det_d    = 1'b1;
                sticky_d = 1'b1;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_W'(1);
                end
                fill_d = overlap ? FILL_MAX : '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            det_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            det_q    <= det_d;
            sticky_q <= sticky_d;
        end
    end

    assign seq_detected    = det_q;
    assign detected_sticky = sticky_q;
    assign match_count     = count_q;

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against two DUT instances.
module tb_pattern_seq_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic       bit_in;
    logic [2:0] pattern;
    logic       overlap;
    logic       clear;

    logic       seq_detected,  detected_sticky;
    logic [7:0] match_count;
    logic       seq_detected2, detected_sticky2;
    logic [1:0] match_count2;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic det;
        logic sticky;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    pattern_seq_detector #(.PAT_W(3), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .pattern(pattern), .overlap(overlap), .clear(clear),
        .seq_detected(seq_detected), .detected_sticky(detected_sticky),
        .match_count(match_count)
    );

    pattern_seq_detector #(.PAT_W(3), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .pattern(pattern), .overlap(overlap), .clear(clear),
        .seq_detected(seq_detected2), .detected_sticky(detected_sticky2),
        .match_count(match_count2)
    );

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: one expectation per applied edge, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("seq_detected",     int'(seq_detected),    int'(mon_e.det));
            check("detected_sticky",  int'(detected_sticky), int'(mon_e.sticky));
            check("match_count",      int'(match_count),     mon_e.cnt);
            check("match_count_sat",  int'(match_count2),    (mon_e.cnt > 3) ? 3 : mon_e.cnt);
            check("seq_detected_sat", int'(seq_detected2),   int'(mon_e.det));
            $display("vec: valid=%0b bit=%0b clr=%0b -> det=%0b sticky=%0b cnt=%0d cnt_sat=%0d",
                     bit_valid, bit_in, clear, seq_detected, detected_sticky,
                     match_count, match_count2);
        end
    end

    task automatic apply(input logic v, input logic b, input logic c,
                         input logic e_det, input logic e_sticky, input int e_cnt);
        exp_t e;
        bit_valid = v;
        bit_in    = b;
        clear     = c;
        @(posedge clk);
        e.det    = e_det;
        e.sticky = e_sticky;
        e.cnt    = e_cnt;
        exp_q.push_back(e);
        #1;
        bit_valid = 1'b0;
        clear     = 1'b0;
    endtask

    // Pulse rst between edges and confirm the outputs drop without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check({tag, "_det"},    int'(seq_detected),    0);
        check({tag, "_sticky"}, int'(detected_sticky), 0);
        check({tag, "_cnt"},    int'(match_count),     0);
        check({tag, "_cnt_sat"},int'(match_count2),    0);
        $display("reset %s: det=%0b sticky=%0b cnt=%0d", tag, seq_detected,
                 detected_sticky, match_count);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        clear     = 1'b0;
        pattern   = 3'b101;
        overlap   = 1'b0;
        #12;
        check("reset_det",    int'(seq_detected),    0);
        check("reset_sticky", int'(detected_sticky), 0);
        check("reset_cnt",    int'(match_count),     0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 1,0,1
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 1, 1);
        apply(0, 0, 0, 0, 1, 1);
        apply(0, 0, 1, 0, 0, 0);

        // Overlapping 1,0,1,0,1
        overlap = 1'b1;
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 1, 1);
        apply(1, 0, 0, 0, 1, 1);
        apply(1, 1, 0, 1, 1, 2);
        apply(0, 0, 1, 0, 0, 0);

        // Non-overlapping 1,0,1,0,1
        overlap = 1'b0;
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 1, 1);
        apply(1, 0, 0, 0, 1, 1);
        apply(1, 1, 0, 0, 1, 1);
        apply(0, 0, 1, 0, 0, 0);

        // Gaps: 1, idle, 0, idle, idle, 1 (idle bit_in set to 1 to expose sampling)
        apply(1, 1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 1, 1);

        // Fill guard with pattern 001: history is zero, a lone 1 must not match
        do_reset("rst_fill");
        pattern = 3'b001;
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 1, 1);

        // Saturation (CNT_W=2 instance) and clear priority
        do_reset("rst_sat");
        pattern = 3'b101;
        overlap = 1'b1;
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 1, 1);
        apply(1, 0, 0, 0, 1, 1);
        apply(1, 1, 0, 1, 1, 2);
        apply(1, 0, 0, 0, 1, 2);
        apply(1, 1, 0, 1, 1, 3);
        apply(1, 0, 0, 0, 1, 3);
        apply(1, 1, 0, 1, 1, 4);
        apply(1, 0, 0, 0, 1, 4);
        apply(1, 1, 1, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 1, 1);

        // Reset mid-sequence: "10" pending must be discarded
        apply(1, 1, 0, 0, 1, 1);
        apply(1, 0, 0, 0, 1, 1);
        do_reset("rst_mid");
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 1, 1, 1);
        apply(0, 0, 0, 0, 1, 1);

        repeat (5) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
